// File: rtl/sprite_draw_engine.sv
// Sprite draw engine: answers a held drawBG/drawChar request by rasterising
// a SPRITE_W x SPRITE_H window. Pixel colours come from the background or
// sprite ROM (both with one cycle of read latency). The block then pulses
// the matching done output.
module sprite_draw_engine #(
  parameter int                  SPRITE_W    = 8,
  parameter int                  SPRITE_H    = 8,
  parameter int                  CHAR_AW     = 6,
  parameter int                  COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = 3'b101,
  parameter int                  SCREEN_W    = 320,
  parameter int                  SCREEN_H    = 240
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                drawBG,
  input  logic                drawChar,
  input  logic [8:0]          xCoordinate,
  input  logic [7:0]          yCoordinate,
  output logic                doneBG,
  output logic                doneChar,
  output logic                busy,
  output logic [CHAR_AW-1:0]  charAddr,
  input  logic [COLOUR_W-1:0] charData,
  output logic [16:0]         bgAddr,
  input  logic [COLOUR_W-1:0] bgData,
  output logic [8:0]          vgaX,
  output logic [7:0]          vgaY,
  output logic [COLOUR_W-1:0] vgaColour,
  output logic                vgaPlot
);

  localparam int CX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CY_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_FLUSH,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic            mode_bg_q, mode_bg_d;   // 1 = background pass, 0 = character pass
  logic [8:0]      x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;
  // Screen position of the address issued last cycle, lined up with ROM data.
  logic [9:0]      px_dly_q, px_dly_d;
  logic [8:0]      py_dly_q, py_dly_d;
  logic            valid_q, valid_d;

  logic [9:0]      px_cur;
  logic [8:0]      py_cur;
  logic            last_col;
  logic            last_row;
  logic            served_req;
  logic            in_screen;
  logic            opaque;

  // Current scan position and the raster-end conditions.
  always_comb begin
    px_cur     = {1'b0, x_q} + 10'(cx_q);
    py_cur     = {1'b0, y_q} + 9'(cy_q);
    last_col   = (cx_q == CX_W'(SPRITE_W - 1));
    last_row   = (cy_q == CY_W'(SPRITE_H - 1));
    served_req = mode_bg_q ? drawBG : drawChar;
  end

  // Next-state logic: request latch, raster counters, pixel pipeline.
  always_comb begin
    state_d   = state_q;
    mode_bg_d = mode_bg_q;
    x_d       = x_q;
    y_d       = y_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    px_dly_d  = px_dly_q;
    py_dly_d  = py_dly_q;
    valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (drawBG || drawChar) begin
          // Background wins when both requests arrive together.
          mode_bg_d = drawBG;
          x_d       = xCoordinate;
          y_d       = yCoordinate;
          cx_d      = '0;
          cy_d      = '0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        valid_d  = 1'b1;
        px_dly_d = px_cur;
        py_dly_d = py_cur;
        if (last_col) begin
          cx_d = '0;
          if (last_row) begin
            cy_d    = '0;
            state_d = S_FLUSH;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      S_FLUSH:   state_d = S_DONE;
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: begin
        // Stay here while the served request is held so it cannot retrigger.
        if (!served_req) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_bg_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      px_dly_q  <= '0;
      py_dly_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_bg_q <= mode_bg_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      px_dly_q  <= px_dly_d;
      py_dly_q  <= py_dly_d;
      valid_q   <= valid_d;
    end
  end

  // Outputs: ROM addresses, handshake flags and the VGA write port.
  always_comb begin
    busy      = (state_q != S_IDLE);
    doneBG    = (state_q == S_DONE) && mode_bg_q;
    doneChar  = (state_q == S_DONE) && !mode_bg_q;
    charAddr  = CHAR_AW'(int'(cy_q) * SPRITE_W + int'(cx_q));
    // The product wraps naturally to 17 bits.
    bgAddr    = (state_q == S_SCAN) ? (17'(py_cur) * 17'(SCREEN_W) + 17'(px_cur)) : '0;
    in_screen = (px_dly_q < 10'(SCREEN_W)) && (py_dly_q < 9'(SCREEN_H));
    opaque    = mode_bg_q || (charData != TRANSPARENT);
    vgaPlot   = valid_q && in_screen && opaque;
    vgaX      = valid_q ? px_dly_q[8:0] : '0;
    vgaY      = valid_q ? py_dly_q[7:0] : '0;
    vgaColour = valid_q ? (mode_bg_q ? bgData : charData) : '0;
  end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine with behavioural background and
// sprite ROMs (one cycle of registered read latency).
module tb_sprite_draw_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        drawBG;
  logic        drawChar;
  logic [8:0]  xCoordinate;
  logic [7:0]  yCoordinate;
  logic        doneBG;
  logic        doneChar;
  logic        busy;
  logic [5:0]  charAddr;
  logic [2:0]  charData;
  logic [16:0] bgAddr;
  logic [2:0]  bgData;
  logic [8:0]  vgaX;
  logic [7:0]  vgaY;
  logic [2:0]  vgaColour;
  logic        vgaPlot;

  logic [2:0]  sprite_rom [64];

  int n_checks = 0;
  int n_fail   = 0;

  sprite_draw_engine dut (
    .clock       (clock),
    .reset       (reset),
    .drawBG      (drawBG),
    .drawChar    (drawChar),
    .xCoordinate (xCoordinate),
    .yCoordinate (yCoordinate),
    .doneBG      (doneBG),
    .doneChar    (doneChar),
    .busy        (busy),
    .charAddr    (charAddr),
    .charData    (charData),
    .bgAddr      (bgAddr),
    .bgData      (bgData),
    .vgaX        (vgaX),
    .vgaY        (vgaY),
    .vgaColour   (vgaColour),
    .vgaPlot     (vgaPlot)
  );

  always #5 clock = ~clock;

  // Background ROM holds the address low bits; the sprite ROM is a table.
  always @(posedge clock) begin
    bgData   <= bgAddr[2:0];
    charData <= sprite_rom[charAddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Colour i%4 everywhere (never 5); entries 0/63 optionally transparent.
  task automatic load_sprite(input bit zero_opaque);
    for (int i = 0; i < 64; i++) sprite_rom[i] = 3'(i % 4);
    if (!zero_opaque) sprite_rom[0] = 3'b101;
    sprite_rom[63] = 3'b101;
  endtask

  // One pass: 'lead' posedges until the request is sampled (E0), then
  // checks every cycle E0+1..E0+66 against the expected raster.
  task automatic run_pass(input bit is_bg, input int x, input int y, input int exp_plots,
                          input int first_addr, input int lead, input int drop_k);
    int  plots;
    int  cx, cy, px, py;
    bit  exp_plot;
    int  exp_col;
    plots = 0;
    repeat (lead) @(posedge clock);
    @(negedge clock);
    check_eq("busy_start", busy, 1);
    if (is_bg) check_eq("bg_addr_first", bgAddr, first_addr);
    else       check_eq("char_addr_first", charAddr, 0);
    for (int k = 1; k <= 66; k++) begin
      @(negedge clock);
      cx = (k - 1) % 8;
      cy = (k - 1) / 8;
      px = x + cx;
      py = y + cy;
      exp_plot = (k <= 64) && (px < 320) && (py < 240) && (is_bg || sprite_rom[k-1] != 3'b101);
      exp_col  = is_bg ? ((py * 320 + px) % 8) : int'(sprite_rom[k-1]);
      check_eq("plot", vgaPlot, exp_plot);
      if (exp_plot) begin
        check_eq("vga_x", vgaX, px);
        check_eq("vga_y", vgaY, py);
        check_eq("vga_colour", vgaColour, exp_col);
      end
      if (vgaPlot) plots++;
      check_eq("done_bg", doneBG, is_bg && (k == 65));
      check_eq("done_char", doneChar, !is_bg && (k == 65));
      check_eq("busy_pass", busy, 1);
      if (k == 3) begin
        xCoordinate = 9'd0;
        yCoordinate = 8'd0;
      end
      if (k == drop_k) begin
        if (is_bg) drawBG = 1'b0;
        else       drawChar = 1'b0;
      end
    end
    check_eq("plot_count", plots, exp_plots);
    xCoordinate = 9'(x);
    yCoordinate = 8'(y);
    $display("pass %s at (%0d,%0d): %0d plots", is_bg ? "BG" : "CHAR", x, y, plots);
  endtask

  initial begin
    reset       = 1'b1;
    drawBG      = 1'b0;
    drawChar    = 1'b0;
    xCoordinate = '0;
    yCoordinate = '0;
    load_sprite(1'b0);

    // Reset then idle with no request.
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_plot", vgaPlot, 0);
      check_eq("rst_done_bg", doneBG, 0);
      check_eq("rst_done_char", doneChar, 0);
      check_eq("rst_vga_x", vgaX, 0);
      check_eq("rst_vga_y", vgaY, 0);
      check_eq("rst_colour", vgaColour, 0);
      check_eq("rst_char_addr", charAddr, 0);
      check_eq("rst_bg_addr", bgAddr, 0);
    end
    $display("reset idle checked");

    // Background pass at (95,221), released after done.
    xCoordinate = 9'd95;
    yCoordinate = 8'd221;
    drawBG = 1'b1;
    run_pass(1'b1, 95, 221, 64, 70815, 1, 0);
    drawBG = 1'b0;
    @(negedge clock);
    check_eq("bg_release_busy", busy, 0);

    // Character pass at (10,10) with corner entries transparent; request drops mid-scan.
    xCoordinate = 9'd10;
    yCoordinate = 8'd10;
    drawChar = 1'b1;
    run_pass(1'b0, 10, 10, 62, 0, 1, 20);
    @(negedge clock);
    check_eq("char_release_busy", busy, 0);

    // Character pass at the bottom-right corner: heavy clipping.
    load_sprite(1'b1);
    xCoordinate = 9'd316;
    yCoordinate = 8'd236;
    drawChar = 1'b1;
    run_pass(1'b0, 316, 236, 16, 0, 1, 0);
    drawChar = 1'b0;
    @(negedge clock);
    check_eq("clip_release_busy", busy, 0);

    // Both requests together: BG first, char after BG is dropped, no repeats.
    load_sprite(1'b0);
    xCoordinate = 9'd40;
    yCoordinate = 8'd50;
    drawBG   = 1'b1;
    drawChar = 1'b1;
    run_pass(1'b1, 40, 50, 64, 16040, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("hold_bg_busy", busy, 1);
      check_eq("hold_bg_done_char", doneChar, 0);
    end
    drawBG = 1'b0;
    run_pass(1'b0, 40, 50, 62, 0, 2, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("hold_char_busy", busy, 1);
      check_eq("hold_char_plot", vgaPlot, 0);
      check_eq("hold_char_done", doneChar, 0);
    end
    drawChar = 1'b0;
    @(negedge clock);
    check_eq("hold_char_release", busy, 0);

    // Reset during the 10th scan cycle.
    xCoordinate = 9'd100;
    yCoordinate = 8'd100;
    drawBG = 1'b1;
    @(posedge clock);
    repeat (9) @(posedge clock);
    @(negedge clock);
    check_eq("pre_reset_plot", vgaPlot, 1);
    reset  = 1'b1;
    drawBG = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("mid_rst_plot", vgaPlot, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_done", doneBG, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      check_eq("post_rst_plot", vgaPlot, 0);
      check_eq("post_rst_done", doneBG, 0);
      check_eq("post_rst_busy", busy, 0);
    end
    $display("mid-scan reset checked");
    drawBG = 1'b1;
    run_pass(1'b1, 100, 100, 64, 32100, 1, 0);
    drawBG = 1'b0;
    @(negedge clock);
    check_eq("restart_release", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
